// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path.
//   clog2   : constant ceil(log2) for sizing counters and addresses
//   bitrev  : reverses the low log2n bits of a value (upper bits cleared)
//   BANK_*  : ping-pong bank select encoding
//   WR_* / RD_* : writer and reader FSM state encodings
package fft_pkg;

  localparam int MAX_LOG2N = 10;
  localparam int IDX_W     = 4;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam logic WR_WAIT_SOF = 1'b0;
  localparam logic WR_FILL     = 1'b1;

  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_READ = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int log2n);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_LOG2N; b++) begin
      if (b < log2n) r[IDX_W'(log2n - 1 - b)] = value[IDX_W'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank complex sample store: 2*N words of DW bits.
//   clk, rst_n         : clock, async active-low reset (read register only)
//   we, wbank, waddr, wdata : write port
//   re, rbank, raddr   : read request; rdata updates one edge later and
//                        holds its value while re is low
// The memory array itself is never reset.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int AW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  // The read register doubles as the block's output data register, so it
  // carries the reset value and holds between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[{rbank, raddr}];
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Streaming bit-reversed to natural order reorder buffer for the SDF FFT.
// Each N-sample input frame is written bit-reversed into one ping-pong bank
// and read back sequentially (bin 0..N-1) while the next frame fills the
// other bank.
//   clk, rst_n        : clock, async active-low reset
//   i_valid, i_sof    : input sample strobe, start of frame (position 0)
//   i_rZ, i_iZ        : input real / imag
//   o_valid, o_sof    : output sample strobe, high with bin 0
//   o_rZ, o_iZ        : output real / imag (hold while o_valid is low)
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [WIDTH-1:0] i_rZ,
  input  logic [WIDTH-1:0] i_iZ,
  output logic             o_valid,
  output logic             o_sof,
  output logic [WIDTH-1:0] o_rZ,
  output logic [WIDTH-1:0] o_iZ
);

  localparam int            AW   = clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic            wr_state;
  logic [AW-1:0]   wr_cnt;
  logic            wr_bank;
  logic [AW-1:0]   wr_pos;
  logic [AW-1:0]   wr_addr;
  logic            wr_en;
  logic            wr_done;

  logic            rd_state;
  logic [AW-1:0]   rd_cnt;
  logic            rd_bank;
  logic            rd_en;
  logic            rd_last;

  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [2*WIDTH-1:0] rd_data;

  // Writer: an i_sof always restarts at position 0 in the current bank,
  // which both starts the first frame and resyncs a partial one.
  always_comb begin
    wr_en   = i_valid && ((wr_state == WR_FILL) || i_sof);
    wr_pos  = i_sof ? '0 : wr_cnt;
    wr_addr = AW'(bitrev(MAX_LOG2N'(wr_pos), AW));
    wr_done = wr_en && !i_sof && (wr_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_WAIT_SOF;
      wr_cnt   <= '0;
      wr_bank  <= BANK_A;
    end else if (wr_en) begin
      wr_state <= WR_FILL;
      if (wr_done) begin
        wr_cnt  <= '0;
        wr_bank <= (wr_bank == BANK_A) ? BANK_B : BANK_A;
      end else begin
        wr_cnt <= wr_pos + 1'b1;
      end
    end
  end

  // Reader: banks complete strictly alternately, so the reader simply
  // follows rd_bank. In IDLE it issues address 0 in the same cycle it sees
  // the bank full, which keeps back-to-back frames gap-free.
  always_comb begin
    rd_en   = (rd_state == RD_READ) || full[rd_bank];
    rd_last = rd_en && (rd_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= BANK_A;
    end else if (rd_en) begin
      if (rd_last) begin
        rd_cnt   <= '0;
        rd_bank  <= ~rd_bank;
        rd_state <= full[~rd_bank] ? RD_READ : RD_IDLE;
      end else begin
        rd_cnt   <= rd_cnt + 1'b1;
        rd_state <= RD_READ;
      end
    end
  end

  // Full flags: writer sets and reader clears only ever touch different banks.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= full_nxt;
  end

  fft_pingpong_ram #(
    .N  (N),
    .DW (2 * WIDTH),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .wbank (wr_bank),
    .waddr (wr_addr),
    .wdata ({i_rZ, i_iZ}),
    .re    (rd_en),
    .rbank (rd_bank),
    .raddr (rd_cnt),
    .rdata (rd_data)
  );

  // Output strobes, aligned with the registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
    end else begin
      o_valid <= rd_en;
      o_sof   <= rd_en && (rd_cnt == '0);
    end
  end

  assign o_rZ = rd_data[2*WIDTH-1:WIDTH];
  assign o_iZ = rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_bitrev_reorder.sv
module tb_bitrev_reorder;

  localparam int N = 16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_sof = 1'b0;
  logic [W-1:0] i_rZ = '0;
  logic [W-1:0] i_iZ = '0;
  logic         o_valid;
  logic         o_sof;
  logic [W-1:0] o_rZ;
  logic [W-1:0] o_iZ;

  bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_rZ    (i_rZ),
    .i_iZ    (i_iZ),
    .o_valid (o_valid),
    .o_sof   (o_sof),
    .o_rZ    (o_rZ),
    .o_iZ    (o_iZ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int run = 0;
  int last_run = 0;

  typedef struct packed {
    logic         sof;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } exp_t;

  exp_t sb[$];

  // Hand-written 4-bit bit-reversal of stream positions 0..15.
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output sample and checks bursts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else if (o_valid) begin
        run++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got sof=%b r=%h i=%h, required no output",
                   o_sof, o_rZ, o_iZ);
        end else begin
          e = sb.pop_front();
          check("bin", {31'd0, o_sof, o_rZ, o_iZ}, {31'd0, e.sof, e.r, e.i});
        end
      end else if (run != 0) begin
        check("burst_len_mod16", 64'(run % N), 64'd0);
        last_run = run;
        run = 0;
      end
    end
  end

  task automatic put(input logic v, input logic s, input logic [W-1:0] r, input logic [W-1:0] i);
    i_valid = v;
    i_sof   = s;
    i_rZ    = r;
    i_iZ    = i;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  // Sends positions 0..cnt-1 carrying r = tag<<8 | bitrev(k), i = ~r.
  // When expect_out is set, bin m of the output is r = tag<<8 | m.
  task automatic send_frame(input int tag, input int cnt, input bit gated, input bit expect_out);
    logic [W-1:0] v;
    exp_t e;
    for (int k = 0; k < cnt; k++) begin
      if (gated) begin
        while ($urandom_range(1, 0) == 1) put(1'b0, 1'b0, 16'h0, 16'h0);
      end
      v = W'((tag << 8) | br[k]);
      put(1'b1, k == 0, v, ~v);
    end
    if (expect_out) begin
      for (int m = 0; m < N; m++) begin
        e.sof = (m == 0);
        e.r   = W'((tag << 8) | m);
        e.i   = ~e.r;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state.
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_sof",   64'(o_sof),   64'd0);
    check("rst_o_rZ",    64'(o_rZ),    64'd0);
    check("rst_o_iZ",    64'(o_iZ),    64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Samples before the first i_sof are dropped.
    for (int k = 0; k < 5; k++) put(1'b1, 1'b0, W'(16'hEE00 | k), W'(16'h1100 | k));
    repeat (4) @(posedge clk);
    #1;

    // Single continuous frame, with latency check.
    send_frame(1, N, 1'b0, 1'b1);
    check("lat_before", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_first", {62'd0, o_valid, o_sof}, 64'd3);
    check("lat_first_r", 64'(o_rZ), 64'h0100);
    drain("drain_single");
    check("single_len", 64'(last_run), 64'd16);

    // Four back-to-back frames.
    for (int f = 0; f < 4; f++) send_frame(2 + f, N, 1'b0, 1'b1);
    drain("drain_b2b");
    check("b2b_len", 64'(last_run), 64'd64);

    // Randomly gated input, three frames.
    for (int f = 0; f < 3; f++) send_frame(8 + f, N, 1'b1, 1'b1);
    drain("drain_gated");
    check("gated_len", 64'(last_run), 64'd16);

    // Resync: 9 abandoned samples, then a full frame.
    send_frame(16'hD, 9, 1'b0, 1'b0);
    send_frame(16'h7, N, 1'b0, 1'b1);
    drain("drain_resync");
    check("resync_len", 64'(last_run), 64'd16);

    // Reset during an output burst.
    send_frame(16'h5, N, 1'b0, 1'b1);
    t = 0;
    while (!o_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("rst_burst_seen", 64'(o_valid), 64'd1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'd0);
    check("async_rst_sof",   64'(o_sof),   64'd0);
    check("async_rst_rZ",    64'(o_rZ),    64'd0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(o_valid), 64'd0);
    send_frame(16'h9, N, 1'b0, 1'b1);
    drain("drain_post_rst");
    check("post_rst_len", 64'(last_run), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
